// File: rtl/core_pkg.sv
// Shared fetch-path types and constants: default reset vector and the
// {pc, instr} response record carried from fetch to decode.
package core_pkg;

    localparam int CORE_XLEN = 32;
    localparam logic [CORE_XLEN-1:0] DEFAULT_RESET_PC = 32'h8000_0000;

    typedef struct packed {
        logic [CORE_XLEN-1:0] pc;
        logic [31:0]          instr;
    } fetch_rsp_t;

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry skid buffer holding a fetched {pc, instr} while decode stalls.
// A flush drops the held entry in the same cycle it is requested.
module fetch_skid_buffer
    import core_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       load,
    input  fetch_rsp_t load_data,
    input  logic       pop,
    output logic       valid,
    output fetch_rsp_t data
);

    logic       valid_q;
    fetch_rsp_t data_q;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            valid_q <= 1'b0;
        end else if (load) begin
            valid_q <= 1'b1;
        end else if (pop) begin
            valid_q <= 1'b0;
        end
    end

    // Payload carries no reset; it is only observed while valid_q is set.
    always_ff @(posedge clk) begin
        if (load) begin
            data_q <= load_data;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, pairs registered imem reads with their PC,
// skid-buffers decode back-pressure. Optional counters under FETCH_PERF_CNT_EN.
module fetch_unit
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          XLEN     = CORE_XLEN
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_pc,
    output logic [31:0]     if_instr,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_stall
);

    logic [XLEN-1:0] pc_q;
    logic            rsp_v_q;
    logic [XLEN-1:0] rsp_pc_q;

    logic       skid_v;
    fetch_rsp_t skid_data;
    fetch_rsp_t rsp_now;
    logic       skid_load;
    logic       issue;

    assign issue   = !skid_v && (!rsp_v_q || if_ready);
    assign rsp_now = '{pc: rsp_pc_q, instr: imem_data};

    // The stalled response is parked only when no redirect is discarding it.
    assign skid_load = rsp_v_q && !if_ready && !skid_v && !redirect_valid;

    always_comb begin
        imem_addr = pc_q;
        if (rst) begin
            imem_addr = RESET_PC;
        end else if (redirect_valid) begin
            imem_addr = redirect_pc;
        end
    end

    assign if_valid = !rst && !redirect_valid && (skid_v || rsp_v_q);
    assign if_pc    = skid_v ? skid_data.pc    : rsp_pc_q;
    assign if_instr = skid_v ? skid_data.instr : imem_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            rsp_v_q <= 1'b0;
        end else if (redirect_valid) begin
            pc_q    <= redirect_pc + XLEN'(4);
            rsp_v_q <= 1'b1;
        end else if (issue) begin
            pc_q    <= pc_q + XLEN'(4);
            rsp_v_q <= 1'b1;
        end else begin
            rsp_v_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (redirect_valid) begin
            rsp_pc_q <= redirect_pc;
        end else if (issue) begin
            rsp_pc_q <= pc_q;
        end
    end

    fetch_skid_buffer u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .load      (skid_load),
        .load_data (rsp_now),
        .pop       (if_ready),
        .valid     (skid_v),
        .data      (skid_data)
    );

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetched_q;
    logic [31:0] stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetched_q <= '0;
            stall_q   <= '0;
        end else begin
            if (if_valid && if_ready) begin
                fetched_q <= fetched_q + 32'd1;
            end
            if (if_valid && !if_ready) begin
                stall_q <= stall_q + 32'd1;
            end
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_stall   = stall_q;
`else
    assign perf_fetched = '0;
    assign perf_stall   = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, a counter sequence, and a
// randomized run checked against a handshake-level model of the fetch stream.
module tb_fetch_unit;

    localparam logic [31:0] B = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] imem_addr;
    logic [31:0] imem_data = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
    bit          mem_mode = 1'b0;

    int nvec = 0;
    int nmis = 0;

    fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .perf_fetched   (perf_fetched),
        .perf_stall     (perf_stall)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memword(input logic [31:0] a, input bit m);
        return m ? ((a * 32'h9E37_79B1) ^ 32'h0000_0013) : 32'h0000_0013;
    endfunction

    // Instruction memory with a one-cycle registered read.
    always @(posedge clk) imem_data <= memword(imem_addr, mem_mode);

    function automatic logic [31:0] exp_cnt(input int c);
`ifdef FETCH_PERF_CNT_EN
        return 32'(c);
`else
        return 32'(c & 0);
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step(input bit r, input bit rd, input bit rv, input logic [31:0] rp);
        @(negedge clk);
        rst = r; if_ready = rd; redirect_valid = rv; redirect_pc = rp;
        #1;
    endtask

    typedef struct {
        bit          r, rd, rv;
        logic [31:0] rp;
        bit          m, ev;
        logic [31:0] epc;
        bit          ca;
        logic [31:0] ea;
    } vec_t;

    function automatic vec_t mk(bit r, bit rd, bit rv, logic [31:0] rp, bit m,
                                bit ev, logic [31:0] epc, bit ca, logic [31:0] ea);
        vec_t t;
        t.r = r; t.rd = rd; t.rv = rv; t.rp = rp; t.m = m;
        t.ev = ev; t.epc = epc; t.ca = ca; t.ea = ea;
        return t;
    endfunction

    vec_t tbl[25];

    initial begin
        int pf, ps;
        logic [31:0] exp_pc;
        bit prev_rst, prev_redir, prev_stall, prev_acc, prev2_stall;

        // reset, stream, stall/release, redirect, redirect over full skid, mid-stream reset
        tbl[0]  = mk(1,1,0,0,       0, 0,0,       1,B);
        tbl[1]  = mk(1,1,0,0,       0, 0,0,       1,B);
        tbl[2]  = mk(0,1,0,0,       0, 0,0,       0,0);
        tbl[3]  = mk(0,1,0,0,       0, 1,B,       0,0);
        tbl[4]  = mk(0,1,0,0,       0, 1,B+4,     0,0);
        tbl[5]  = mk(0,0,0,0,       0, 1,B+8,     0,0);
        tbl[6]  = mk(0,0,0,0,       0, 1,B+8,     0,0);
        tbl[7]  = mk(0,0,0,0,       0, 1,B+8,     0,0);
        tbl[8]  = mk(0,1,0,0,       0, 1,B+8,     0,0);
        tbl[9]  = mk(0,1,0,0,       0, 0,0,       0,0);
        tbl[10] = mk(0,1,0,0,       0, 1,B+12,    0,0);
        tbl[11] = mk(0,1,0,0,       0, 1,B+16,    0,0);
        tbl[12] = mk(0,1,1,B+32'h100,1, 0,0,      1,B+32'h100);
        tbl[13] = mk(0,1,0,0,       1, 1,B+32'h100,0,0);
        tbl[14] = mk(0,1,0,0,       1, 1,B+32'h104,0,0);
        tbl[15] = mk(0,0,0,0,       1, 1,B+32'h108,0,0);
        tbl[16] = mk(0,0,0,0,       1, 1,B+32'h108,0,0);
        tbl[17] = mk(0,0,1,B+32'h200,1, 0,0,      1,B+32'h200);
        tbl[18] = mk(0,1,0,0,       1, 1,B+32'h200,0,0);
        tbl[19] = mk(0,1,0,0,       1, 1,B+32'h204,0,0);
        tbl[20] = mk(0,1,1,B+32'h40,1, 0,0,       1,B+32'h40);
        tbl[21] = mk(1,1,0,0,       1, 0,0,       1,B);
        tbl[22] = mk(0,1,0,0,       1, 0,0,       0,0);
        tbl[23] = mk(0,1,0,0,       1, 1,B,       0,0);
        tbl[24] = mk(0,1,0,0,       1, 1,B+4,     0,0);

        pf = 0; ps = 0;
        for (int i = 0; i < 25; i++) begin
            mem_mode = tbl[i].m;
            step(tbl[i].r, tbl[i].rd, tbl[i].rv, tbl[i].rp);
            chk($sformatf("tbl%0d valid", i), 32'(if_valid), 32'(tbl[i].ev));
            if (tbl[i].ev) begin
                chk($sformatf("tbl%0d pc", i), if_pc, tbl[i].epc);
                chk($sformatf("tbl%0d instr", i), if_instr, memword(tbl[i].epc, tbl[i].m));
            end
            if (tbl[i].ca) chk($sformatf("tbl%0d addr", i), imem_addr, tbl[i].ea);
            chk($sformatf("tbl%0d fetched", i), perf_fetched, exp_cnt(pf));
            chk($sformatf("tbl%0d stall", i), perf_stall, exp_cnt(ps));
            if (tbl[i].r) begin
                pf = 0; ps = 0;
            end else if (tbl[i].ev && tbl[i].rd) pf++;
            else if (tbl[i].ev) ps++;
        end

        // Ten accepted instructions after a fresh reset.
        step(1, 1, 0, 0);
        step(0, 1, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        chk("ten fetched", perf_fetched, exp_cnt(10));
        chk("ten stall", perf_stall, exp_cnt(0));
        chk("ten pc", if_pc, B + 32'd40);

        // Randomized traffic against the stream model.
        mem_mode = 1'b1;
        pf = 0; ps = 0; exp_pc = B;
        prev_rst = 1; prev_redir = 0; prev_stall = 0; prev_acc = 0; prev2_stall = 0;
        for (int i = 0; i < 2000; i++) begin
            bit r, rd, rv, ev, stall_now, acc_now;
            logic [31:0] rp;
            int sel;
            r  = (i == 0) || ($urandom_range(0, 99) < 2);
            rd = $urandom_range(0, 99) < 70;
            rv = $urandom_range(0, 99) < 10;
            sel = $urandom_range(0, 2);
            rp = (sel == 0) ? 32'hFFFF_FFF0 + 32'(4 * $urandom_range(0, 3)) :
                 (sel == 1) ? ($urandom() & 32'hFFFF_FFFC) : $urandom();
            step(r, rd, rv, rp);
            ev = 0;
            if (r) begin
                chk("rnd rst valid", 32'(if_valid), 32'd0);
                chk("rnd rst addr", imem_addr, B);
            end else if (rv) begin
                chk("rnd redir valid", 32'(if_valid), 32'd0);
                chk("rnd redir addr", imem_addr, rp);
            end else begin
                if (prev_rst) ev = 0;
                else if (prev_redir || prev_stall) ev = 1;
                else if (prev_acc) ev = !prev2_stall;
                else ev = 1;
                chk($sformatf("rnd%0d valid", i), 32'(if_valid), 32'(ev));
                if (ev) begin
                    chk($sformatf("rnd%0d pc", i), if_pc, exp_pc);
                    chk($sformatf("rnd%0d instr", i), if_instr, memword(exp_pc, 1'b1));
                end
            end
            chk($sformatf("rnd%0d fetched", i), perf_fetched, exp_cnt(pf));
            chk($sformatf("rnd%0d stall", i), perf_stall, exp_cnt(ps));

            stall_now = !r && !rv && ev && !rd;
            acc_now   = !r && !rv && ev && rd;
            if (r) begin
                pf = 0; ps = 0; exp_pc = B;
            end else if (rv) begin
                exp_pc = rp;
            end else begin
                if (acc_now) begin pf++; exp_pc = exp_pc + 32'd4; end
                if (stall_now) ps++;
            end
            prev2_stall = prev_stall;
            prev_stall  = stall_now;
            prev_acc    = acc_now;
            prev_rst    = r;
            prev_redir  = !r && rv;
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
